wave_reg_writer: RTL and testbench
==================================

Name: wave_reg_writer

Overview:
- CPU-side register front end for the wave channel. It writes the channel's control inputs; the channel itself reads them.
- Decodes byte writes and reads to NR30–NR34 (FF1A–FF1E) and wave RAM (FF30–FF3F).
- Holds register state and drives the channel's enable, vol, len_load, trigger, len_enable, freq and samples inputs.
- Generates single-cycle trigger/length-load strobes and returns masked read-back data.

Parameters:
- REG_BASE, 8'h1A, low address byte of NR30; NR31..NR34 follow consecutively.
- WAVE_BASE, 8'h30, low address byte of the first wave RAM byte; 16 bytes.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- addr  in  8  low byte of FFxx bus address
- wdata  in  8  write data
- wr  in  1  write strobe, one cycle per access
- rd  in  1  read strobe, one cycle per access
- rdata  out  8  read data, valid when rvalid=1
- rvalid  out  1  one-cycle pulse, read response
- enable  out  1  DAC power, NR30[7]
- vol  out  2  volume code, NR32[6:5]
- len_load  out  6  NR31[5:0]
- len_strobe  out  1  one-cycle pulse after any NR31 write
- trigger  out  1  one-cycle pulse, NR34 write with bit7=1 and DAC on
- len_enable  out  1  NR34[6]
- freq  out  11  {NR34[2:0], NR33}
- samples  out  32x4 (128)  sample k at bits [4k+3:4k]

Behaviour:
- Reset (async, rst=1): all registers 0; enable=0, vol=0, len_load=0, len_enable=0, freq=0, samples=0, trigger=0, len_strobe=0, rvalid=0, rdata=8'h00.
- Bus is always ready, with no wait states. One access per strobe cycle.
- Write: on posedge with wr=1, the addressed register updates. New value is visible on outputs in the following cycle (1-cycle latency).
- NR30: stores bit7 only. Writing bit7=0 drops enable the next cycle, regardless of trigger.
- NR31: stores all 8 bits; len_load drives the low 6 bits. len_strobe pulses for exactly 1 cycle, the cycle after the write.
- NR32: stores bits 6:5.
- NR33: stores 8 bits, freq[7:0].
- NR34:
  - Stores bit6 (len_enable) and bits 2:0 (freq[10:8]).
  - Bit7 is not stored; it is write-only.
  - trigger pulses 1 cycle after the write only if bit7=1 and enable (post-write value) is 1; otherwise no pulse.
- Wave RAM: byte i (addr=WAVE_BASE+i) holds sample 2i in [7:4] and sample 2i+1 in [3:0]. Writes are accepted regardless of enable.
- Read: on posedge with rd=1, rdata is registered and rvalid=1 for one cycle (1-cycle latency). Read values:
  - NR30 = reg|8'h7F
  - NR31 = 8'hFF (write-only)
  - NR32 = reg|8'h9F
  - NR33 = 8'hFF
  - NR34 = reg|8'hBF
  - wave bytes read back raw
  - unmapped addresses (FF1F–FF2F, others) read 8'hFF
- Unmapped writes are ignored and produce no strobes.
- rd and wr in the same cycle to the same address: both are performed; rdata returns the pre-write value.
- Back-to-back NR34 triggers on consecutive cycles give consecutive trigger pulses with no merging.
- Reset asserted mid-access: pending strobes and rvalid clear immediately; the access is lost.
- rdata holds its last value when rvalid=0.

Decomposition:
- Shared package `wave_regs_pkg`:
  - address constants NR30..NR34 and WAVE_BASE
  - read-OR masks (7F, FF, 9F, FF, BF)
  - unmapped read value 8'hFF
- Sub-module `wave_ram16x8`:
  - 16-byte write port and read port
  - flattened 128-bit samples view with nibble ordering as above
  - async reset to 0

Test Plan:
- Reset then read NR30, NR32, NR34, FF20 -> rdata 7F, 9F, BF, FF, each with a single rvalid pulse one cycle after rd.
- Write NR30=80, NR33=34, NR34=C5 -> next cycle freq=11'h534, len_enable=1, trigger high exactly 1 cycle; NR34 read = FF.
- Write NR30=00, then NR34=80 -> no trigger pulse, enable=0.
- Write FF30=A5 and FF3F=3C -> samples[0]=A, samples[1]=5, samples[30]=3, samples[31]=C; FF30 read = A5.
- Write NR31=FB -> len_load=6'h3B, len_strobe 1 cycle; simultaneous rd+wr NR32 (old 00, new 60) -> rdata 9F, then vol=3.
- Assert rst while len_strobe/rvalid are high -> both drop without waiting for clk; all outputs 0.

Source files
------------

// File: rtl/wave_regs_pkg.sv
// Shared address map and read-back masks for the wave channel register front end.
package wave_regs_pkg;

    localparam logic [7:0] NR30_ADDR      = 8'h1A;
    localparam logic [7:0] NR31_ADDR      = 8'h1B;
    localparam logic [7:0] NR32_ADDR      = 8'h1C;
    localparam logic [7:0] NR33_ADDR      = 8'h1D;
    localparam logic [7:0] NR34_ADDR      = 8'h1E;
    localparam logic [7:0] WAVE_BASE_ADDR = 8'h30;

    localparam int unsigned NUM_REGS   = 5;
    localparam int unsigned WAVE_BYTES = 16;

    // Bits that always read back as 1 (unimplemented or write-only)
    localparam logic [7:0] NR30_RMASK = 8'h7F;
    localparam logic [7:0] NR31_RMASK = 8'hFF;
    localparam logic [7:0] NR32_RMASK = 8'h9F;
    localparam logic [7:0] NR33_RMASK = 8'hFF;
    localparam logic [7:0] NR34_RMASK = 8'hBF;

    localparam logic [7:0] UNMAPPED_RD = 8'hFF;

endpackage

// File: rtl/wave_ram16x8.sv
// 16-byte wave sample RAM with a flattened 32 x 4-bit sample view.
module wave_ram16x8
    import wave_regs_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we,
    input  logic [3:0]   i_waddr,
    input  logic [7:0]   i_wdata,
    input  logic [3:0]   i_raddr,
    output logic [7:0]   o_rdata,
    output logic [127:0] o_samples
);

    logic [7:0] r_mem [WAVE_BYTES];

    // Byte write port, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < WAVE_BYTES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read port; the caller registers the result
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

    // Byte i holds sample 2i in its high nibble and sample 2i+1 in its low nibble
    always_comb begin
        o_samples = '0;
        for (int unsigned i = 0; i < WAVE_BYTES; i++) begin
            o_samples[8*i +: 8] = {r_mem[i][3:0], r_mem[i][7:4]};
        end
    end

endmodule

// File: rtl/wave_reg_writer.sv
// CPU-side register front end for the wave channel: NR30-NR34 and wave RAM.
module wave_reg_writer
    import wave_regs_pkg::*;
#(
    parameter logic [7:0] REG_BASE  = NR30_ADDR,
    parameter logic [7:0] WAVE_BASE = WAVE_BASE_ADDR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   addr,
    input  logic [7:0]   wdata,
    input  logic         wr,
    input  logic         rd,
    output logic [7:0]   rdata,
    output logic         rvalid,
    output logic         enable,
    output logic [1:0]   vol,
    output logic [5:0]   len_load,
    output logic         len_strobe,
    output logic         trigger,
    output logic         len_enable,
    output logic [10:0]  freq,
    output logic [127:0] samples
);

    logic       r_enable;
    logic [5:0] r_len;       // NR31[7:6] are never observable, so only [5:0] is kept
    logic [1:0] r_vol;
    logic [7:0] r_freq_lo;
    logic [2:0] r_freq_hi;
    logic       r_len_en;
    logic       r_trigger;
    logic       r_len_strobe;
    logic [7:0] r_rdata;
    logic       r_rvalid;

    logic [7:0] w_reg_off;
    logic [7:0] w_wave_off;
    logic       w_reg_hit;
    logic       w_wave_hit;
    logic [7:0] w_ram_rdata;
    logic [7:0] w_rd_val;

    // Address decode relative to the two windows
    always_comb begin
        w_reg_off  = addr - REG_BASE;
        w_wave_off = addr - WAVE_BASE;
        w_reg_hit  = (w_reg_off < 8'(NUM_REGS));
        w_wave_hit = (w_wave_off < 8'(WAVE_BYTES));
    end

    wave_ram16x8 u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_we      (wr && w_wave_hit),
        .i_waddr   (w_wave_off[3:0]),
        .i_wdata   (wdata),
        .i_raddr   (w_wave_off[3:0]),
        .o_rdata   (w_ram_rdata),
        .o_samples (samples)
    );

    // Register writes and single-cycle trigger / length-load strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable     <= 1'b0;
            r_len        <= '0;
            r_vol        <= '0;
            r_freq_lo    <= '0;
            r_freq_hi    <= '0;
            r_len_en     <= 1'b0;
            r_trigger    <= 1'b0;
            r_len_strobe <= 1'b0;
        end else begin
            r_trigger    <= 1'b0;
            r_len_strobe <= 1'b0;
            if (wr && w_reg_hit) begin
                case (w_reg_off[2:0])
                    3'd0: r_enable <= wdata[7];
                    3'd1: begin
                        r_len        <= wdata[5:0];
                        r_len_strobe <= 1'b1;
                    end
                    3'd2: r_vol     <= wdata[6:5];
                    3'd3: r_freq_lo <= wdata;
                    3'd4: begin
                        r_len_en  <= wdata[6];
                        r_freq_hi <= wdata[2:0];
                        // NR30 cannot be written in the same cycle, so r_enable is the post-write value
                        r_trigger <= wdata[7] & r_enable;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read-back value from current (pre-write) state with unimplemented bits forced high
    always_comb begin
        w_rd_val = UNMAPPED_RD;
        if (w_reg_hit) begin
            case (w_reg_off[2:0])
                3'd0:    w_rd_val = {r_enable, 7'b0} | NR30_RMASK;
                3'd1:    w_rd_val = NR31_RMASK;
                3'd2:    w_rd_val = {1'b0, r_vol, 5'b0} | NR32_RMASK;
                3'd3:    w_rd_val = NR33_RMASK;
                3'd4:    w_rd_val = {1'b0, r_len_en, 3'b0, r_freq_hi} | NR34_RMASK;
                default: w_rd_val = UNMAPPED_RD;
            endcase
        end else if (w_wave_hit) begin
            w_rd_val = w_ram_rdata;
        end
    end

    // Registered read response; rdata holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= rd;
            if (rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign rdata      = r_rdata;
    assign rvalid     = r_rvalid;
    assign enable     = r_enable;
    assign vol        = r_vol;
    assign len_load   = r_len;
    assign len_strobe = r_len_strobe;
    assign trigger    = r_trigger;
    assign len_enable = r_len_en;
    assign freq       = {r_freq_hi, r_freq_lo};

endmodule

// File: tb/tb_wave_reg_writer.sv
// Self-checking bench for wave_reg_writer: directed scenarios plus a randomized run
// checked against a register-level behavioural model.
module tb_wave_reg_writer;

    logic         clk;
    logic         rst;
    logic [7:0]   addr;
    logic [7:0]   wdata;
    logic         wr;
    logic         rd;
    logic [7:0]   rdata;
    logic         rvalid;
    logic         enable;
    logic [1:0]   vol;
    logic [5:0]   len_load;
    logic         len_strobe;
    logic         trigger;
    logic         len_enable;
    logic [10:0]  freq;
    logic [127:0] samples;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic       m_en;
    logic [1:0] m_vol;
    logic [5:0] m_len;
    logic [10:0] m_freq;
    logic       m_len_en;
    logic [7:0] m_ram [16];
    logic [7:0] exp_rdata;
    logic       exp_rvalid;
    logic       exp_trig;
    logic       exp_lstr;

    wave_reg_writer #(.REG_BASE(8'h1A), .WAVE_BASE(8'h30)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .wdata      (wdata),
        .wr         (wr),
        .rd         (rd),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .enable     (enable),
        .vol        (vol),
        .len_load   (len_load),
        .len_strobe (len_strobe),
        .trigger    (trigger),
        .len_enable (len_enable),
        .freq       (freq),
        .samples    (samples)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_en = 0; m_vol = 0; m_len = 0; m_freq = 0; m_len_en = 0;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        exp_rdata = 8'h00; exp_rvalid = 0; exp_trig = 0; exp_lstr = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a >= 8'h30 && a <= 8'h3F) return m_ram[a - 8'h30];
        case (a)
            8'h1A:   return {m_en, 7'h7F};
            8'h1C:   return {1'b1, m_vol, 5'h1F};
            8'h1E:   return {1'b1, m_len_en, 6'h3F};
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [127:0] model_samples();
        logic [127:0] s;
        logic [7:0]   b;
        s = '0;
        for (int k = 0; k < 32; k++) begin
            b = m_ram[k / 2];
            s[4*k +: 4] = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
        return s;
    endfunction

    task automatic model_apply(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        exp_trig = 0;
        exp_lstr = 0;
        exp_rvalid = r;
        if (r) exp_rdata = model_read(a);
        if (w) begin
            if (a >= 8'h30 && a <= 8'h3F) m_ram[a - 8'h30] = d;
            else case (a)
                8'h1A: m_en = d[7];
                8'h1B: begin m_len = d[5:0]; exp_lstr = 1; end
                8'h1C: m_vol = d[6:5];
                8'h1D: m_freq[7:0] = d;
                8'h1E: begin
                    m_len_en = d[6];
                    m_freq[10:8] = d[2:0];
                    exp_trig = d[7] && m_en;
                end
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive at negedge, returns 1 time unit after the capturing posedge
    task automatic drive(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wr = w; rd = r; addr = a; wdata = d;
        model_apply(w, r, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] ra [4];
        logic [7:0] rexp [4];
        ra[0] = 8'h1A; ra[1] = 8'h1C; ra[2] = 8'h1E; ra[3] = 8'h20;
        rexp[0] = 8'h7F; rexp[1] = 8'h9F; rexp[2] = 8'hBF; rexp[3] = 8'hFF;
        rst = 1; wr = 0; rd = 0; addr = 0; wdata = 0;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({rdata, rvalid, enable, vol, len_load, len_strobe, trigger, len_enable, freq} !== '0 || samples !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdata=%h rvalid=%b en=%b vol=%h len=%h ls=%b trig=%b le=%b freq=%h samples=%h required all zero",
                     rdata, rvalid, enable, vol, len_load, len_strobe, trigger, len_enable, freq, samples);
        end
        @(negedge clk); rst = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, ra[i], 8'h00);
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== rexp[i]) begin
                n_fail++;
                $display("FAIL reset_read_%h: got rvalid=%b rdata=%h required rvalid=1 rdata=%h", ra[i], rvalid, rdata, rexp[i]);
            end
            drive(0, 0, 8'h00, 8'h00);
            n_checks++;
            if (rvalid !== 1'b0 || rdata !== rexp[i]) begin
                n_fail++;
                $display("FAIL reset_read_hold_%h: got rvalid=%b rdata=%h required rvalid=0 rdata=%h", ra[i], rvalid, rdata, rexp[i]);
            end
        end
    endtask

    task automatic test_trigger();
        drive(1, 0, 8'h1A, 8'h80);
        drive(1, 0, 8'h1D, 8'h34);
        drive(1, 0, 8'h1E, 8'hC5);
        n_checks++;
        if (freq !== 11'h534 || len_enable !== 1'b1 || trigger !== 1'b1 || enable !== 1'b1) begin
            n_fail++;
            $display("FAIL trigger_write: got freq=%h le=%b trig=%b en=%b required freq=534 le=1 trig=1 en=1", freq, len_enable, trigger, enable);
        end
        drive(0, 1, 8'h1E, 8'h00);
        n_checks++;
        if (trigger !== 1'b0 || rvalid !== 1'b1 || rdata !== 8'hFF) begin
            n_fail++;
            $display("FAIL trigger_pulse_end: got trig=%b rvalid=%b rdata=%h required trig=0 rvalid=1 rdata=ff", trigger, rvalid, rdata);
        end
    endtask

    task automatic test_no_trigger();
        drive(1, 0, 8'h1A, 8'h00);
        n_checks++;
        if (enable !== 1'b0) begin
            n_fail++;
            $display("FAIL dac_off: got enable=%b required 0", enable);
        end
        drive(1, 0, 8'h1E, 8'h80);
        n_checks++;
        if (trigger !== 1'b0 || enable !== 1'b0) begin
            n_fail++;
            $display("FAIL no_trigger: got trig=%b en=%b required trig=0 en=0", trigger, enable);
        end
        drive(0, 0, 8'h00, 8'h00);
        n_checks++;
        if (trigger !== 1'b0) begin
            n_fail++;
            $display("FAIL no_trigger_late: got trig=%b required 0", trigger);
        end
    endtask

    task automatic test_wave_ram();
        drive(1, 0, 8'h30, 8'hA5);
        drive(1, 0, 8'h3F, 8'h3C);
        n_checks++;
        if (samples[3:0] !== 4'hA || samples[7:4] !== 4'h5 || samples[123:120] !== 4'h3 || samples[127:124] !== 4'hC) begin
            n_fail++;
            $display("FAIL wave_samples: got s0=%h s1=%h s30=%h s31=%h required a 5 3 c",
                     samples[3:0], samples[7:4], samples[123:120], samples[127:124]);
        end
        drive(0, 1, 8'h30, 8'h00);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL wave_read: got rvalid=%b rdata=%h required 1 a5", rvalid, rdata);
        end
    endtask

    task automatic test_len_and_rdwr();
        drive(1, 0, 8'h1B, 8'hFB);
        n_checks++;
        if (len_load !== 6'h3B || len_strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL len_write: got len=%h ls=%b required 3b 1", len_load, len_strobe);
        end
        drive(0, 0, 8'h00, 8'h00);
        n_checks++;
        if (len_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL len_strobe_width: got ls=%b required 0", len_strobe);
        end
        drive(1, 1, 8'h1C, 8'h60);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h9F || vol !== 2'd3) begin
            n_fail++;
            $display("FAIL rdwr_same: got rvalid=%b rdata=%h vol=%h required 1 9f 3", rvalid, rdata, vol);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        drive(1, 0, 8'h1A, 8'h80);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h1E, 8'h80);
            if (trigger === 1'b1) pulses++;
        end
        drive(0, 0, 8'h00, 8'h00);
        n_checks++;
        if (pulses != 3 || trigger !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: got pulses=%0d trig_after=%b required 3 0", pulses, trigger);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] d;
        int sel;
        for (int it = 0; it < 400; it++) begin
            sel = $urandom_range(0, 99);
            if (sel < 45)      a = 8'h1A + 8'($urandom_range(0, 4));
            else if (sel < 80) a = 8'h30 + 8'($urandom_range(0, 15));
            else               a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
            n_checks++;
            if (rvalid !== exp_rvalid || rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL rand_read it=%0d addr=%h: got rvalid=%b rdata=%h required %b %h", it, a, rvalid, rdata, exp_rvalid, exp_rdata);
            end
            n_checks++;
            if (trigger !== exp_trig || len_strobe !== exp_lstr) begin
                n_fail++;
                $display("FAIL rand_strobes it=%0d: got trig=%b ls=%b required %b %b", it, trigger, len_strobe, exp_trig, exp_lstr);
            end
            n_checks++;
            if (enable !== m_en || vol !== m_vol || len_load !== m_len || freq !== m_freq || len_enable !== m_len_en) begin
                n_fail++;
                $display("FAIL rand_regs it=%0d: got en=%b vol=%h len=%h freq=%h le=%b required %b %h %h %h %b",
                         it, enable, vol, len_load, freq, len_enable, m_en, m_vol, m_len, m_freq, m_len_en);
            end
            n_checks++;
            if (samples !== model_samples()) begin
                n_fail++;
                $display("FAIL rand_samples it=%0d: got %h required %h", it, samples, model_samples());
            end
        end
    endtask

    task automatic test_reset_midaccess();
        drive(1, 1, 8'h1B, 8'h55);
        n_checks++;
        if (len_strobe !== 1'b1 || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: got ls=%b rvalid=%b required 1 1", len_strobe, rvalid);
        end
        #1;
        rst = 1;
        model_reset();
        #1;
        n_checks++;
        if ({rdata, rvalid, enable, vol, len_load, len_strobe, trigger, len_enable, freq} !== '0 || samples !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got rdata=%h rvalid=%b en=%b vol=%h len=%h ls=%b trig=%b le=%b freq=%h required all zero",
                     rdata, rvalid, enable, vol, len_load, len_strobe, trigger, len_enable, freq);
        end
        wr = 0; rd = 0;
        @(negedge clk);
        rst = 0;
        drive(0, 1, 8'h1A, 8'h00);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 8'h7F) begin
            n_fail++;
            $display("FAIL midreset_after: got rvalid=%b rdata=%h required 1 7f", rvalid, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_no_trigger();
        test_wave_ram();
        test_len_and_rdwr();
        test_back_to_back();
        test_random();
        test_reset_midaccess();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
